axi_r_allocator_rr: RTL and testbench

Read-data backward allocator for one target port of the AXI node. It merges R beats from N_INIT_PORT initiator-side ports onto one R channel using burst-locked round-robin arbitration. It tracks outstanding read bursts in a parametrised saturating counter. It queues several decode-error descriptors in a small FIFO and emits each as a DECERR burst once all older transactions have drained.

---
 rtl/axi_node_pkg.sv | 15 +
 rtl/axi_rr_burst_arbiter.sv | 65 ++++++
 rtl/axi_r_allocator_rr.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_r_allocator_rr.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_node_pkg.sv
// Shared constants and types for the AXI node allocators.
// Covers response codes, error burst length width and the allocator state encoding.
package axi_node_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int         ERR_LEN_W   = 8;

  typedef enum logic [1:0] {
    ST_OPERATIVE = 2'd0,
    ST_ERR_WAIT  = 2'd1,
    ST_ERR_BURST = 2'd2
  } alloc_state_t;

endpackage

// File: rtl/axi_rr_burst_arbiter.sv
// Burst-locked round-robin arbiter: a grant, once a beat is accepted, stays until the
// beat flagged last is accepted; the pointer then moves to the port after the winner.
module axi_rr_burst_arbiter #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  input  logic         ready,
  output logic [N-1:0] grant,
  output logic         valid,
  output logic         locked
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] lock_idx_q;
  logic             lock_q;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] gidx;
  logic             found;
  logic             fire;

  always_comb begin
    pick_idx = ptr_q;
    cand     = ptr_q;
    found    = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr_q) + 32'(k)) % N);
      if (!found && req[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    gidx  = lock_q ? lock_idx_q : pick_idx;
    valid = lock_q ? req[lock_idx_q] : found;
    grant = '0;
    if (lock_q || found) grant[gidx] = 1'b1;
  end

  assign fire   = valid & ready;
  assign locked = lock_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      lock_idx_q <= '0;
      lock_q     <= 1'b0;
    end else if (fire) begin
      if (last[gidx]) begin
        lock_q <= 1'b0;
        ptr_q  <= (gidx == IDX_W'(N - 1)) ? '0 : gidx + 1'b1;
      end else begin
        lock_q     <= 1'b1;
        lock_idx_q <= gidx;
      end
    end
  end

endmodule

// File: rtl/axi_r_allocator_rr.sv
// R-channel allocator for one target port: merges initiator R beats by burst-locked
// round robin, tracks outstanding reads and emits queued decode errors as DECERR bursts.
//
// state        | meaning
// OPERATIVE    | forwarding only, error FIFO empty
// ERR_WAIT     | forwarding, error queued until reads drain and no burst is locked
// ERR_BURST    | driving DECERR beats from the captured descriptor
module axi_r_allocator_rr
  import axi_node_pkg::*;
#(
  parameter int          N_INIT_PORT    = 4,
  parameter int          N_TARG_PORT    = 8,
  parameter int          AXI_DATA_W     = 64,
  parameter int          AXI_ID_IN      = 16,
  parameter int          AXI_ID_OUT     = AXI_ID_IN + $clog2(N_TARG_PORT),
  parameter int          AXI_USER_W     = 6,
  parameter int          CNT_W          = 10,
  parameter int          ERR_FIFO_DEPTH = 4,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [N_INIT_PORT-1:0][AXI_ID_OUT-1:0]  rid_i,
  input  logic [N_INIT_PORT-1:0][AXI_DATA_W-1:0]  rdata_i,
  input  logic [N_INIT_PORT-1:0][1:0]             rresp_i,
  input  logic [N_INIT_PORT-1:0]                  rlast_i,
  input  logic [N_INIT_PORT-1:0][AXI_USER_W-1:0]  ruser_i,
  input  logic [N_INIT_PORT-1:0]                  rvalid_i,
  output logic [N_INIT_PORT-1:0]                  rready_o,
  output logic [AXI_ID_IN-1:0]                    rid_o,
  output logic [AXI_DATA_W-1:0]                   rdata_o,
  output logic [1:0]                              rresp_o,
  output logic                                    rlast_o,
  output logic [AXI_USER_W-1:0]                   ruser_o,
  output logic                                    rvalid_o,
  input  logic                                    rready_i,
  input  logic                                    incr_req_i,
  output logic                                    full_counter_o,
  output logic                                    outstanding_trans_o,
  input  logic                                    err_valid_i,
  output logic                                    err_ready_o,
  input  logic [AXI_ID_IN-1:0]                    err_id_i,
  input  logic [ERR_LEN_W-1:0]                    err_len_i,
  input  logic [AXI_USER_W-1:0]                   err_user_i,
  output logic                                    err_pending_o,
  output logic                                    err_done_o
);

  localparam int DATA_WORDS = AXI_DATA_W / 32;
  localparam int PTR_W      = $clog2(ERR_FIFO_DEPTH);

  typedef struct packed {
    logic [AXI_ID_IN-1:0]  id;
    logic [ERR_LEN_W-1:0]  len;
    logic [AXI_USER_W-1:0] user;
  } err_desc_t;

  alloc_state_t state_q, state_d;

  logic [N_INIT_PORT-1:0] grant;
  logic                   arb_valid;
  logic                   arb_locked;
  logic                   arb_ready;
  logic                   fwd_en;

  logic [AXI_ID_IN-1:0]   fwd_id;
  logic [AXI_DATA_W-1:0]  fwd_data;
  logic [1:0]             fwd_resp;
  logic                   fwd_last;
  logic [AXI_USER_W-1:0]  fwd_user;

  logic [CNT_W-1:0]       cnt_q;
  logic                   incr;
  logic                   decr;

  err_desc_t              fifo_mem [ERR_FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr_q, rd_ptr_q;
  logic                   fifo_empty, fifo_full;
  logic                   push, pop;
  err_desc_t              cur_q;
  logic [ERR_LEN_W-1:0]   beat_cnt_q;
  logic                   err_last;

  logic                   unused_rid;
  assign unused_rid = ^rid_i;

  assign fwd_en    = (state_q != ST_ERR_BURST);
  assign arb_ready = rready_i & fwd_en;

  if (N_INIT_PORT > 1) begin : g_arb
    axi_rr_burst_arbiter #(.N(N_INIT_PORT)) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (rvalid_i),
      .last   (rlast_i),
      .ready  (arb_ready),
      .grant  (grant),
      .valid  (arb_valid),
      .locked (arb_locked)
    );
  end else begin : g_bypass
    // A single port still needs to know it is mid-burst before an error may be emitted.
    logic in_burst_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       in_burst_q <= 1'b0;
      else if (rvalid_i[0] & arb_ready) in_burst_q <= ~rlast_i[0];
    end
    assign grant      = '1;
    assign arb_valid  = rvalid_i[0];
    assign arb_locked = in_burst_q;
  end

  always_comb begin
    fwd_id   = '0;
    fwd_data = '0;
    fwd_resp = '0;
    fwd_last = 1'b0;
    fwd_user = '0;
    for (int p = 0; p < N_INIT_PORT; p++) begin
      if (grant[p]) begin
        fwd_id   = rid_i[p][AXI_ID_IN-1:0];
        fwd_data = rdata_i[p];
        fwd_resp = rresp_i[p];
        fwd_last = rlast_i[p];
        fwd_user = ruser_i[p];
      end
    end
  end

  assign err_last = (beat_cnt_q == cur_q.len);

  always_comb begin
    if (state_q == ST_ERR_BURST) begin
      rvalid_o = 1'b1;
      rid_o    = cur_q.id;
      rdata_o  = {DATA_WORDS{ERR_DATA}};
      rresp_o  = RESP_DECERR;
      rlast_o  = err_last;
      ruser_o  = cur_q.user;
    end else begin
      rvalid_o = arb_valid;
      rid_o    = fwd_id;
      rdata_o  = fwd_data;
      rresp_o  = fwd_resp;
      rlast_o  = fwd_last;
      ruser_o  = fwd_user;
    end
  end

  assign rready_o = grant & {N_INIT_PORT{arb_ready}};

  // Error bursts never retire a counted read, so decrement only on forwarded last beats.
  assign incr = incr_req_i;
  assign decr = fwd_en & arb_valid & rready_i & fwd_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (incr && !decr && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (decr && !incr && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign full_counter_o      = (cnt_q == '1);
  assign outstanding_trans_o = (cnt_q != '0);

  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign err_ready_o = ~fifo_full;
  assign push        = err_valid_i & ~fifo_full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= '{id: err_id_i, len: err_len_i, user: err_user_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    err_done_o = 1'b0;
    case (state_q)
      ST_OPERATIVE: begin
        if (!fifo_empty) state_d = ST_ERR_WAIT;
      end
      ST_ERR_WAIT: begin
        if ((cnt_q == '0) && !arb_locked && !fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ERR_BURST;
        end
      end
      ST_ERR_BURST: begin
        if (rready_i && err_last) begin
          err_done_o = 1'b1;
          state_d    = fifo_empty ? ST_OPERATIVE : ST_ERR_WAIT;
        end
      end
      default: state_d = ST_OPERATIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OPERATIVE;
      cur_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        cur_q      <= fifo_mem[rd_ptr_q[PTR_W-1:0]];
        beat_cnt_q <= '0;
      end else if ((state_q == ST_ERR_BURST) && rready_i && !err_last) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
    end
  end

  assign err_pending_o = ~fifo_empty | (state_q == ST_ERR_BURST);

endmodule

// File: tb/tb_axi_r_allocator_rr.sv
// Scoreboard bench for the R allocator: stimulus pushes expected beats computed from
// round-robin order and error descriptors; a negedge monitor pops and compares.
module tb_axi_r_allocator_rr;

  localparam int N    = 4;
  localparam int IDI  = 16;
  localparam int IDO  = IDI + 3;
  localparam int DW   = 64;
  localparam int UW   = 6;
  localparam int CMAX = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0][IDO-1:0] rid_i = '0;
  logic [N-1:0][DW-1:0]  rdata_i = '0;
  logic [N-1:0][1:0]     rresp_i = '0;
  logic [N-1:0]          rlast_i = '0;
  logic [N-1:0][UW-1:0]  ruser_i = '0;
  logic [N-1:0]          rvalid_i = '0;
  logic [N-1:0]          rready_o;
  logic [IDI-1:0]        rid_o;
  logic [DW-1:0]         rdata_o;
  logic [1:0]            rresp_o;
  logic                  rlast_o;
  logic [UW-1:0]         ruser_o;
  logic                  rvalid_o;
  logic                  rready_i = 1'b0;
  logic                  incr_req_i = 1'b0;
  logic                  full_counter_o;
  logic                  outstanding_trans_o;
  logic                  err_valid_i = 1'b0;
  logic                  err_ready_o;
  logic [IDI-1:0]        err_id_i = '0;
  logic [7:0]            err_len_i = '0;
  logic [UW-1:0]         err_user_i = '0;
  logic                  err_pending_o;
  logic                  err_done_o;

  axi_r_allocator_rr dut (
    .clk(clk), .rst_n(rst_n),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .ruser_i(ruser_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .ruser_o(ruser_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .incr_req_i(incr_req_i), .full_counter_o(full_counter_o),
    .outstanding_trans_o(outstanding_trans_o),
    .err_valid_i(err_valid_i), .err_ready_o(err_ready_o), .err_id_i(err_id_i),
    .err_len_i(err_len_i), .err_user_i(err_user_i),
    .err_pending_o(err_pending_o), .err_done_o(err_done_o)
  );

  typedef struct {
    logic [IDO-1:0] id;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
    logic [UW-1:0]  user;
    int             gap;
  } beat_t;

  typedef struct {
    logic [IDI-1:0] id;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
    logic [UW-1:0]  user;
    bit             err;
  } exp_t;

  int tests = 0;
  int fails = 0;
  exp_t  sb[$];
  beat_t pq[N][$];
  int gap_left[N];
  int ptr_m = 0;
  int cnt_m = 0;
  int pending = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int rr_mode = 0;
  logic [N-1:0] acc;
  logic err_rdy_s;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rvalid_o && rready_i) begin
      hs_cnt++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat got id=%h data=%h resp=%b last=%b", rid_o, rdata_o, rresp_o, rlast_o);
      end else begin
        e = sb.pop_front();
        if (rid_o !== e.id || rdata_o !== e.data || rresp_o !== e.resp || rlast_o !== e.last ||
            ruser_o !== e.user || err_done_o !== (e.err && e.last)) begin
          fails++;
          $display("FAIL r_beat got id=%h data=%h resp=%b last=%b user=%h done=%b, want id=%h data=%h resp=%b last=%b user=%h done=%b",
                   rid_o, rdata_o, rresp_o, rlast_o, ruser_o, err_done_o,
                   e.id, e.data, e.resp, e.last, e.user, e.err && e.last);
        end
      end
    end
    if (rst_n && err_done_o) done_cnt++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  task automatic drive_ports();
    for (int p = 0; p < N; p++) begin
      if (pq[p].size() > 0) begin
        rvalid_i[p] = (gap_left[p] == 0);
        rid_i[p]    = pq[p][0].id;
        rdata_i[p]  = pq[p][0].data;
        rresp_i[p]  = pq[p][0].resp;
        rlast_i[p]  = pq[p][0].last;
        ruser_i[p]  = pq[p][0].user;
      end else begin
        rvalid_i[p] = 1'b0;
        rid_i[p]    = '0;
        rdata_i[p]  = '0;
        rresp_i[p]  = '0;
        rlast_i[p]  = 1'b0;
        ruser_i[p]  = '0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    acc = rvalid_i & rready_o;
    err_rdy_s = err_ready_o;
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) begin
      if (acc[p]) begin
        void'(pq[p].pop_front());
        gap_left[p] = (pq[p].size() > 0) ? pq[p][0].gap : 0;
      end else if (gap_left[p] > 0) begin
        gap_left[p]--;
      end
    end
    case (rr_mode)
      0:       rready_i = 1'b1;
      1:       rready_i = 1'($urandom_range(0, 1));
      2:       rready_i = ~rready_i;
      default: rready_i = 1'b0;
    endcase
    drive_ports();
  endtask

  task automatic pulse_incr(input int n);
    incr_req_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      step();
      cnt_m = (cnt_m < CMAX) ? cnt_m + 1 : CMAX;
    end
    incr_req_i = 1'b0;
  endtask

  // Each masked port gets one burst; all first beats appear together, so the
  // service order is plain round robin from the modelled pointer.
  task automatic load_round(input logic [N-1:0] mask, input int lmin, input int lmax,
                            input int gapmax, input int hold_port, input int hold_gap,
                            input bit do_incr);
    int nb;
    int lastp;
    nb = $countones(mask);
    if (nb == 0) return;
    if (do_incr) pulse_incr(nb);
    pending += nb;
    for (int p = 0; p < N; p++) begin
      if (mask[p]) begin
        int n;
        n = $urandom_range(lmin, lmax);
        for (int b = 0; b < n; b++) begin
          beat_t bt;
          bt.id   = IDO'($urandom);
          bt.data = {$urandom, $urandom};
          bt.resp = 2'($urandom_range(0, 3));
          bt.last = (b == n - 1);
          bt.user = UW'($urandom);
          bt.gap  = (b == 0) ? 0 : $urandom_range(0, gapmax);
          if (p == hold_port && b == 1) bt.gap = hold_gap;
          pq[p].push_back(bt);
        end
        gap_left[p] = 0;
      end
    end
    lastp = 0;
    for (int k = 0; k < N; k++) begin
      int p;
      p = (ptr_m + k) % N;
      if (mask[p]) begin
        foreach (pq[p][i]) begin
          exp_t e;
          e.id = pq[p][i].id[IDI-1:0]; e.data = pq[p][i].data; e.resp = pq[p][i].resp;
          e.last = pq[p][i].last; e.user = pq[p][i].user; e.err = 1'b0;
          sb.push_back(e);
        end
        lastp = p;
      end
    end
    ptr_m = (lastp + 1) % N;
    drive_ports();
  endtask

  task automatic push_err(input logic [IDI-1:0] id, input logic [7:0] len,
                          input logic [UW-1:0] user, input logic want_ready);
    err_valid_i = 1'b1;
    err_id_i    = id;
    err_len_i   = len;
    err_user_i  = user;
    step();
    chk("err_ready", 64'(err_rdy_s), 64'(want_ready));
    if (err_rdy_s) begin
      for (int b = 0; b <= int'(len); b++) begin
        exp_t e;
        e.id = id; e.data = {2{32'hDEADBEEF}}; e.resp = 2'b11;
        e.last = (b == int'(len)); e.user = user; e.err = 1'b1;
        sb.push_back(e);
      end
      exp_done++;
    end
  endtask

  task automatic drain(input string tag, input int bound);
    int c;
    bit busy;
    c = 0;
    busy = 1'b1;
    while (busy && c < bound) begin
      busy = (sb.size() != 0) || err_pending_o;
      for (int p = 0; p < N; p++) if (pq[p].size() != 0) busy = 1'b1;
      if (busy) begin
        step();
        c++;
      end
    end
    chk({tag, "_drained"}, 64'(busy), 64'(0));
    for (int i = 0; i < pending; i++) cnt_m = (cnt_m > 0) ? cnt_m - 1 : 0;
    pending = 0;
    chk({tag, "_outstanding"}, 64'(outstanding_trans_o), 64'(cnt_m != 0));
    chk({tag, "_full"}, 64'(full_counter_o), 64'(cnt_m == CMAX));
    chk({tag, "_done_count"}, 64'(done_cnt), 64'(exp_done));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sb.delete();
    for (int p = 0; p < N; p++) begin
      pq[p].delete();
      gap_left[p] = 0;
    end
    incr_req_i  = 1'b0;
    err_valid_i = 1'b0;
    rready_i    = 1'b0;
    rr_mode     = 0;
    drive_ports();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rvalid", 64'(rvalid_o), 64'(0));
    chk("rst_rready", 64'(rready_o), 64'(0));
    chk("rst_err_ready", 64'(err_ready_o), 64'(1));
    chk("rst_err_pending", 64'(err_pending_o), 64'(0));
    chk("rst_err_done", 64'(err_done_o), 64'(0));
    chk("rst_outstanding", 64'(outstanding_trans_o), 64'(0));
    chk("rst_full", 64'(full_counter_o), 64'(0));
    @(posedge clk);
    #1;
    cnt_m = 0;
    ptr_m = 0;
    pending = 0;
    exp_done = done_cnt;
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    int c;
    apply_reset();

    // Two simultaneous 4-beat bursts from pointer 0, then rounds probing the pointer.
    rr_mode = 0;
    load_round(4'b0101, 4, 4, 0, -1, 0, 1'b1);
    drain("rr_0_2", 200);
    load_round(4'b1010, 3, 3, 0, -1, 0, 1'b1);
    drain("rr_ptr3", 200);
    load_round(4'b0001, 2, 2, 0, -1, 0, 1'b1);
    drain("rr_single", 200);

    // Port 1 (pointer at 1) drops valid for 3 cycles mid-burst while port 0 waits.
    load_round(4'b0011, 4, 4, 0, 1, 3, 1'b1);
    drain("lock_hold", 200);

    // Counter: 3 incr, 2 decr, then incr and decr in the same cycle.
    pulse_incr(3);
    load_round(4'b0110, 1, 1, 0, -1, 0, 1'b0);
    drain("cnt_decr2", 200);
    rr_mode = 3;
    load_round(4'b1000, 1, 1, 0, -1, 0, 1'b0);
    rready_i   = 1'b1;
    incr_req_i = 1'b1;
    step();
    incr_req_i = 1'b0;
    cnt_m = (cnt_m < CMAX) ? cnt_m + 1 : CMAX;
    rr_mode = 0;
    drain("cnt_both", 200);
    chk("cnt_one_outstanding", 64'(outstanding_trans_o), 64'(1));
    pulse_incr(1022);
    chk("cnt_full", 64'(full_counter_o), 64'(cnt_m == CMAX));
    pulse_incr(1);
    load_round(4'b0001, 1, 1, 0, -1, 0, 1'b0);
    drain("cnt_sat_hold", 200);
    apply_reset();

    // Counter=2, one DECERR burst of 4 beats waits for both reads to complete.
    rr_mode = 3;
    rready_i = 1'b0;
    load_round(4'b0101, 2, 4, 1, -1, 0, 1'b1);
    push_err(16'd5, 8'd3, 6'h2a, 1'b1);
    err_valid_i = 1'b0;
    rr_mode = 0;
    drain("err_single", 500);

    // Four queued errors fill the FIFO; a fifth is refused; rready toggles.
    rr_mode = 3;
    rready_i = 1'b0;
    load_round(4'b0100, 2, 4, 0, -1, 0, 1'b1);
    for (int i = 0; i < 4; i++) push_err(IDI'(16'h100 + i), 8'($urandom_range(0, 3)), UW'(i), 1'b1);
    push_err(16'h1ff, 8'd1, 6'h3f, 1'b0);
    err_valid_i = 1'b0;
    rr_mode = 2;
    drain("err_fifo_full", 800);

    // Length boundaries: 256-beat and single-beat error bursts.
    rr_mode = 1;
    push_err(16'hbeef, 8'd255, 6'h11, 1'b1);
    push_err(16'h0001, 8'd0, 6'h22, 1'b1);
    err_valid_i = 1'b0;
    drain("err_len_edges", 2000);

    // Randomised rounds with random bubbles, ready patterns and interleaved errors.
    for (int r = 0; r < 20; r++) begin
      int ne;
      rr_mode = $urandom_range(0, 2);
      load_round(4'($urandom_range(0, 15)), 1, 6, 2, -1, 0, 1'b1);
      ne = $urandom_range(0, 2);
      for (int k = 0; k < ne; k++) push_err(IDI'($urandom), 8'($urandom_range(0, 6)), UW'($urandom), 1'b1);
      err_valid_i = 1'b0;
      drain("random_round", 3000);
    end

    // Reset asserted while the second beat of an error burst is presented.
    rr_mode = 0;
    hs0 = hs_cnt;
    push_err(16'h0abc, 8'd5, 6'h05, 1'b1);
    err_valid_i = 1'b0;
    c = 0;
    while (hs_cnt < hs0 + 1 && c < 50) begin
      step();
      c++;
    end
    chk("rst_mid_reached", 64'(hs_cnt >= hs0 + 1), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", 64'(rvalid_o), 64'(0));
    apply_reset();

    // Traffic after the mid-burst reset restarts from pointer 0.
    load_round(4'b1001, 2, 3, 1, -1, 0, 1'b1);
    drain("post_reset", 300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
